// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one physical memory port between the pipeline's IF and MEM requesters.
// Serves one transaction at a time. MEM wins ties, but after STARVE_LIMIT
// consecutive MEM grants while IF was waiting, IF is forced ahead. The winner's
// request is captured at grant, so later requester changes cannot disturb the
// physical port until the transaction completes.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_read,
    input  logic                  if_write,
    input  logic [1:0]            if_wmask,
    input  logic [ADDR_WIDTH-1:0] if_address,
    input  logic [DATA_WIDTH-1:0] if_wdata,
    output logic                  if_resp,
    output logic [DATA_WIDTH-1:0] if_rdata,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [1:0]            mem_wmask,
    input  logic [ADDR_WIDTH-1:0] mem_address,
    input  logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_resp,
    output logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [1:0]            pmem_wmask,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [DATA_WIDTH-1:0] pmem_wdata,
    input  logic                  pmem_resp,
    input  logic [DATA_WIDTH-1:0] pmem_rdata
);
    localparam int CNT_WIDTH = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_WIDTH-1:0] LIMIT = CNT_WIDTH'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SERVE_IF  = 2'd1,
        SERVE_MEM = 2'd2
    } state_t;

    state_t                state;
    logic [CNT_WIDTH-1:0]  starve_cnt;
    logic                  lat_read;
    logic                  lat_write;
    logic [1:0]            lat_wmask;
    logic [ADDR_WIDTH-1:0] lat_address;
    logic [DATA_WIDTH-1:0] lat_wdata;

    logic                  if_req;
    logic                  mem_req;
    logic                  grant_mem;
    logic                  sel_read;
    logic                  sel_write;
    logic [1:0]            sel_wmask;
    logic [ADDR_WIDTH-1:0] sel_address;
    logic [DATA_WIDTH-1:0] sel_wdata;

    assign if_req    = if_read | if_write;
    assign mem_req   = mem_read | mem_write;
    // MEM wins unless IF is waiting and has already been passed over too often
    assign grant_mem = mem_req && !(if_req && (starve_cnt >= LIMIT));

    // Pick the fields of whichever port would win; a write masks a simultaneous read
    always_comb begin
        sel_write   = grant_mem ? mem_write   : if_write;
        sel_read    = (grant_mem ? mem_read : if_read) & ~sel_write;
        sel_wmask   = grant_mem ? mem_wmask   : if_wmask;
        sel_address = grant_mem ? mem_address : if_address;
        sel_wdata   = grant_mem ? mem_wdata   : if_wdata;
    end

    // Arbitration FSM: grant in IDLE, hold the captured request until pmem_resp
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            starve_cnt  <= '0;
            lat_read    <= 1'b0;
            lat_write   <= 1'b0;
            lat_wmask   <= '0;
            lat_address <= '0;
            lat_wdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_mem || if_req) begin
                        state       <= grant_mem ? SERVE_MEM : SERVE_IF;
                        lat_read    <= sel_read;
                        lat_write   <= sel_write;
                        lat_wmask   <= sel_wmask;
                        lat_address <= sel_address;
                        lat_wdata   <= sel_wdata;
                    end
                    // Count only MEM grants that overtook a waiting IF
                    if (grant_mem && if_req) begin
                        starve_cnt <= (starve_cnt >= LIMIT) ? LIMIT : starve_cnt + 1'b1;
                    end else begin
                        starve_cnt <= '0;
                    end
                end
                SERVE_IF, SERVE_MEM: begin
                    if (pmem_resp) begin
                        state     <= IDLE;
                        lat_read  <= 1'b0;
                        lat_write <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    lat_read  <= 1'b0;
                    lat_write <= 1'b0;
                end
            endcase
        end
    end

    // Strobes come straight from the captured request; they are cleared outside a transaction
    assign pmem_read    = lat_read;
    assign pmem_write   = lat_write;
    assign pmem_wmask   = lat_wmask;
    assign pmem_address = lat_address;
    assign pmem_wdata   = lat_wdata;

    // Completion is routed only to the port currently being served
    assign if_resp   = (state == SERVE_IF)  && pmem_resp;
    assign mem_resp  = (state == SERVE_MEM) && pmem_resp;
    assign if_rdata  = (state == SERVE_IF)  ? pmem_rdata : '0;
    assign mem_rdata = (state == SERVE_MEM) ? pmem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two requester agents, a physical-memory responder,
// a transaction-level reference arbiter and a scoreboard of expected pmem
// requests and requester responses.
module tb_mem_port_arbiter;
    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_read = 0, if_write = 0, mem_read = 0, mem_write = 0;
    logic [1:0]  if_wmask = 0, mem_wmask = 0;
    logic [15:0] if_address = 0, if_wdata = 0, mem_address = 0, mem_wdata = 0;
    logic        if_resp, mem_resp, pmem_read, pmem_write;
    logic [15:0] if_rdata, mem_rdata, pmem_address, pmem_wdata;
    logic [1:0]  pmem_wmask;
    logic        pmem_resp = 1'b0;
    logic [15:0] pmem_rdata = 16'h0;

    typedef struct { logic rd; logic wr; logic [1:0] m; logic [15:0] a; logic [15:0] d; } preq_t;
    typedef struct { bit port; logic [15:0] d; } resp_t;

    preq_t       pmem_q[$];
    resp_t       resp_q[$];
    bit          grant_log[$];
    logic [15:0] ref_mem [8];
    logic [15:0] pm [8];
    int          total = 0, bad = 0;
    int          force_lat = -1;
    bit          spur_en = 0, spur_force = 0;
    bit          m_busy = 0, m_owner = 0, ifp, mp;
    int          m_streak = 0;

    mem_port_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_read(if_read), .if_write(if_write), .if_wmask(if_wmask),
        .if_address(if_address), .if_wdata(if_wdata), .if_resp(if_resp), .if_rdata(if_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_wmask(mem_wmask),
        .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_resp(mem_resp), .mem_rdata(mem_rdata),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_wmask(pmem_wmask),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] bytes(input logic [1:0] m);
        return {{8{m[1]}}, {8{m[0]}}};
    endfunction

    // Reference arbiter: capture the request the winning port holds at the decision edge
    task automatic grant(input bit p);
        preq_t q;
        resp_t r;
        int    i;
        q.wr = p ? mem_write : if_write;
        q.rd = (p ? mem_read : if_read) && !q.wr;
        q.m  = p ? mem_wmask : if_wmask;
        q.a  = p ? mem_address : if_address;
        q.d  = p ? mem_wdata : if_wdata;
        i = int'(q.a[2:0]);
        r.port = p;
        r.d = ref_mem[i];
        if (q.wr) ref_mem[i] = (ref_mem[i] & ~bytes(q.m)) | (q.d & bytes(q.m));
        pmem_q.push_back(q);
        resp_q.push_back(r);
        m_busy = 1;
        m_owner = p;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                m_busy = 0; m_streak = 0;
                pmem_q.delete(); resp_q.delete();
            end else if (m_busy) begin
                if (pmem_resp) m_busy = 0;
            end else begin
                ifp = if_read | if_write;
                mp  = mem_read | mem_write;
                if (mp && !(ifp && m_streak >= LIMIT)) begin
                    grant(1'b1);
                    m_streak = ifp ? ((m_streak + 1 > LIMIT) ? LIMIT : m_streak + 1) : 0;
                end else begin
                    if (ifp) grant(1'b0);
                    m_streak = 0;
                end
            end
        end
    end

    // Physical memory responder followed by the output monitor
    initial begin
        bit    act = 0;
        int    wait_left = 0;
        preq_t e;
        resp_t r;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                act = 0; pmem_resp = 0;
            end else if (pmem_read || pmem_write) begin
                if (!act) begin
                    act = 1;
                    wait_left = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 3));
                    if (pmem_q.size() == 0) begin
                        chk("pmem_unexpected_txn", 64'(pmem_address), 64'hFFFF_FFFF);
                    end else begin
                        e = pmem_q.pop_front();
                        chk("pmem_read", 64'(pmem_read), 64'(e.rd));
                        chk("pmem_write", 64'(pmem_write), 64'(e.wr));
                        chk("pmem_wmask", 64'(pmem_wmask), 64'(e.m));
                        chk("pmem_address", 64'(pmem_address), 64'(e.a));
                        chk("pmem_wdata", 64'(pmem_wdata), 64'(e.d));
                    end
                end
                if (wait_left == 0) begin
                    pmem_resp = 1;
                    pmem_rdata = pm[pmem_address[2:0]];
                    if (pmem_write)
                        pm[pmem_address[2:0]] = (pm[pmem_address[2:0]] & ~bytes(pmem_wmask))
                                                | (pmem_wdata & bytes(pmem_wmask));
                    act = 0;
                end else begin
                    pmem_resp = 0;
                    pmem_rdata = 16'($urandom);
                    wait_left--;
                end
            end else begin
                act = 0;
                pmem_resp = spur_force || (spur_en && $urandom_range(0, 5) == 0);
                pmem_rdata = 16'($urandom);
            end
            #2;
            if (!rst_n || !m_busy) begin
                chk("idle_quiet", 64'({pmem_read, pmem_write, if_resp, mem_resp, if_rdata, mem_rdata}), 64'h0);
            end else begin
                chk("if_resp_route", 64'(if_resp), 64'(!m_owner && pmem_resp));
                chk("mem_resp_route", 64'(mem_resp), 64'(m_owner && pmem_resp));
                chk("if_rdata_route", 64'(if_rdata), m_owner ? 64'h0 : 64'(pmem_rdata));
                chk("mem_rdata_route", 64'(mem_rdata), m_owner ? 64'(pmem_rdata) : 64'h0);
            end
            if (if_resp || mem_resp) begin
                if (resp_q.size() == 0) begin
                    chk("resp_unexpected", 64'({if_resp, mem_resp}), 64'h0);
                end else begin
                    r = resp_q.pop_front();
                    chk("resp_port", 64'(mem_resp), 64'(r.port));
                    chk("resp_rdata", 64'(mem_resp ? mem_rdata : if_rdata), 64'(r.d));
                    grant_log.push_back(mem_resp);
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #3;
    endtask

    task automatic set_port(input bit p, input logic rd, input logic wr, input logic [1:0] m,
                            input logic [15:0] a, input logic [15:0] d);
        if (!p) begin
            if_read = rd; if_write = wr; if_wmask = m; if_address = a; if_wdata = d;
        end else begin
            mem_read = rd; mem_write = wr; mem_wmask = m; mem_address = a; mem_wdata = d;
        end
    endtask

    function automatic logic got_resp(input bit p);
        return p ? mem_resp : if_resp;
    endfunction

    task automatic wait_resp(input bit p, input string name);
        int n = 0;
        do begin
            step();
            n++;
        end while (!got_resp(p) && n < 300);
        chk(name, 64'(got_resp(p)), 64'h1);
    endtask

    // Requester agent: n transactions, random gap, holds each request until its response
    task automatic run_port(input bit p, input int n, input int maxgap);
        for (int i = 0; i < n; i++) begin
            int gap = $urandom_range(0, maxgap);
            int k = $urandom_range(0, 2);
            if (gap > 0) begin
                set_port(p, 0, 0, 2'b00, 16'h0, 16'h0);
                repeat (gap) step();
            end
            set_port(p, k != 1, k != 0, 2'($urandom), 16'($urandom), 16'($urandom));
            wait_resp(p, p ? "mem_agent_resp" : "if_agent_resp");
        end
        set_port(p, 0, 0, 2'b00, 16'h0, 16'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] order;
        for (int i = 0; i < 8; i++) begin
            pm[i] = 16'($urandom);
            ref_mem[i] = pm[i];
        end
        repeat (2) @(negedge clk);
        #2;
        chk("rst_strobes", 64'({pmem_read, pmem_write}), 64'h0);
        chk("rst_pmem_addr", 64'(pmem_address), 64'h0);
        chk("rst_pmem_wdata", 64'(pmem_wdata), 64'h0);
        chk("rst_pmem_wmask", 64'(pmem_wmask), 64'h0);
        chk("rst_resps", 64'({if_resp, mem_resp}), 64'h0);
        #1 rst_n = 1;
        repeat (3) step();

        // IF read alone, two wait states
        force_lat = 2;
        pm[0] = 16'h1234; ref_mem[0] = 16'h1234;
        set_port(0, 1, 0, 2'b00, 16'h0010, 16'h0);
        step(); chk("t1_c1_read", 64'(pmem_read), 64'h1); chk("t1_c1_resp", 64'(if_resp), 64'h0);
        step(); chk("t1_c2_read", 64'(pmem_read), 64'h1); chk("t1_c2_resp", 64'(if_resp), 64'h0);
        step(); chk("t1_c3_read", 64'(pmem_read), 64'h1); chk("t1_c3_resp", 64'(if_resp), 64'h1);
        chk("t1_c3_rdata", 64'(if_rdata), 64'h1234); chk("t1_c3_addr", 64'(pmem_address), 64'h0010);
        set_port(0, 0, 0, 2'b00, 16'h0, 16'h0);
        step(); chk("t1_c4_read", 64'(pmem_read), 64'h0);

        // Simultaneous IF read and MEM write: MEM first, one idle cycle, then IF
        repeat (2) step();
        force_lat = 0;
        set_port(0, 1, 0, 2'b00, 16'h0020, 16'h0);
        set_port(1, 0, 1, 2'b01, 16'h0200, 16'hBEEF);
        step();
        chk("t2_write", 64'({pmem_write, pmem_read}), 64'h2);
        chk("t2_wmask", 64'(pmem_wmask), 64'h1);
        chk("t2_wdata", 64'(pmem_wdata), 64'hBEEF);
        chk("t2_mem_resp", 64'(mem_resp), 64'h1);
        set_port(1, 0, 0, 2'b00, 16'h0, 16'h0);
        step(); chk("t2_gap", 64'({pmem_read, pmem_write}), 64'h0);
        step(); chk("t2_if_read", 64'(pmem_read), 64'h1); chk("t2_if_resp", 64'(if_resp), 64'h1);
        set_port(0, 0, 0, 2'b00, 16'h0, 16'h0);

        // Starvation guard: IF held while MEM re-requests back-to-back
        repeat (2) step();
        grant_log.delete();
        fork
            run_port(0, 1, 0);
            run_port(1, 6, 0);
        join
        chk("t3_grants", 64'(grant_log.size()), 64'd7);
        order = '0;
        foreach (grant_log[i]) if (i < 7) order = {order[5:0], grant_log[i]};
        chk("t3_order", 64'(order), 64'b1111011);

        // Read+write together, address changed after grant
        repeat (2) step();
        force_lat = 1;
        set_port(1, 1, 1, 2'b10, 16'h0304, 16'hCAFE);
        step();
        chk("t4_strobes", 64'({pmem_write, pmem_read}), 64'h2);
        chk("t4_addr", 64'(pmem_address), 64'h0304);
        mem_address = 16'h0ABC; mem_wdata = 16'h1111;
        step();
        chk("t4_addr_held", 64'(pmem_address), 64'h0304);
        chk("t4_wdata_held", 64'(pmem_wdata), 64'hCAFE);
        chk("t4_resp", 64'(mem_resp), 64'h1);
        set_port(1, 0, 0, 2'b00, 16'h0, 16'h0);

        // Reset in the middle of a MEM transaction
        repeat (2) step();
        force_lat = 3;
        set_port(1, 1, 0, 2'b00, 16'h0006, 16'h0);
        step(); chk("t5_read", 64'(pmem_read), 64'h1);
        step();
        rst_n = 0;
        #1;
        chk("t5_abort_strobe", 64'({pmem_read, pmem_write}), 64'h0);
        chk("t5_abort_resp", 64'(mem_resp), 64'h0);
        step(); step();
        rst_n = 1;
        force_lat = 0;
        wait_resp(1, "t5_reserved");
        set_port(1, 0, 0, 2'b00, 16'h0, 16'h0);

        // Spurious pmem_resp while idle
        repeat (2) step();
        spur_force = 1;
        step(); chk("t6_no_resp", 64'({if_resp, mem_resp}), 64'h0);
        spur_force = 0;
        step(); chk("t6_still_idle", 64'({pmem_read, pmem_write}), 64'h0);
        set_port(0, 0, 1, 2'b11, 16'h0002, 16'h5A5A);
        wait_resp(0, "t6_after_spur");
        set_port(0, 0, 0, 2'b00, 16'h0, 16'h0);

        // Random traffic on both ports with random latency and spurious responses
        repeat (2) step();
        force_lat = -1;
        spur_en = 1;
        fork
            run_port(0, 25, 3);
            run_port(1, 25, 3);
        join
        spur_en = 0;
        repeat (5) step();
        chk("end_resp_q", 64'(resp_q.size()), 64'h0);
        chk("end_pmem_q", 64'(pmem_q.size()), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
